hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller. Drives the write-enable, flush and bubble controls for the PC,
//  IF/ID, ID/EX and EX/MEM pipeline registers. Detects load-use hazards, taken branches and
//  jumps, and data-memory wait states. Sits beside the ID stage and feeds the wr_en and flush
//  inputs of every pipeline register.
// PARAMETERS
//  MAX_WAIT  64  number of consecutive MEM_WAIT cycles after which mem_timeout is raised
//  CNT_W     32  width of the performance counters (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk             in   1   system clock, rising edge
//  rst_n           in   1   asynchronous reset, active low
//  id_rs           in   5   rs field of the instruction in ID
//  id_rt           in   5   rt field of the instruction in ID
//  id_uses_rs      in   1   ID instruction reads rs
//  id_uses_rt      in   1   ID instruction reads rt
//  id_jump         in   1   J/JAL/JR resolved in ID (PCSrc != PC+4)
//  ex_MemRead      in   1   MemRead of the instruction in EX (ID/EX output)
//  ex_rd           in   5   destination register of the instruction in EX
//  ex_branch_taken in   1   branch in EX resolved taken
//  mem_busy        in   1   data memory not ready; MEM stage must hold
//  pc_wr_en        out  1   PC update enable
//  if_id_wr_en     out  1   IF/ID write enable
//  if_id_flush     out  1   IF/ID loads a NOP
//  id_ex_wr_en     out  1   ID/EX write enable
//  id_ex_bubble    out  1   ID/EX loads all-zero controls (RegWrite/MemRead/MemWrite/Branch = 0)
//  ex_mem_wr_en    out  1   EX/MEM write enable
//  mem_timeout     out  1   sticky flag: MEM_WAIT lasted MAX_WAIT cycles
// BEHAVIOUR
//  - Reset (rst_n=0): state=RUN, pend_flush=0, wait_cnt=0, mem_timeout=0. All wr_en, flush
//    and bubble outputs are 0 while rst_n=0. Counters are cleared.
//  - Enables/flushes are combinational from the current inputs, state and pend_flush, so
//    hazards act in the same cycle. Zero added latency.
//  - Default (no hazard): all wr_en=1, flush/bubble=0.
//  - Priority, highest first: mem_busy > (ex_branch_taken | pend_flush) > load-use > id_jump.
//  - mem_busy=1: pc/if_id/id_ex/ex_mem wr_en=0, no flush/bubble. state<=MEM_WAIT.
//    wait_cnt increments and saturates at MAX_WAIT. wait_cnt==MAX_WAIT sets mem_timeout (sticky
//    until reset). The stall continues regardless of the timeout.
//  - If ex_branch_taken=1 while mem_busy=1, then pend_flush<=1.
//  - mem_busy falls: state<=RUN, wait_cnt<=0. In that first RUN cycle, pend_flush=1 forces
//    the branch response; pend_flush is cleared at the end of the cycle.
//  - Branch response: pc_wr_en=1, if_id_flush=1, id_ex_bubble=1 (id_ex_wr_en=1), ex_mem_wr_en=1.
//    Load-use is ignored because the ID instruction is squashed.
//  - Load-use: ex_MemRead & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
//    Response: pc_wr_en=0, if_id_wr_en=0, id_ex_bubble=1, ex_mem_wr_en=1. Lasts exactly one
//    cycle; the hazard clears once the load leaves EX.
//  - id_jump with no higher-priority event: if_id_flush=1, other enables 1.
//    id_jump during a load-use stall: the stall wins and the jump is taken on the retry cycle.
//  - Register $0 is never a hazard source.
//  - States: RUN -(mem_busy)-> MEM_WAIT -(!mem_busy)-> RUN. No other states.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[CNT_W-1:0] and flush_count[CNT_W-1:0].
//    stall_cycles increments on each cycle with pc_wr_en=0.
//    flush_count increments on each cycle with if_id_flush=1.
//    Both counters saturate at all-ones and reset to 0.
//  HAZARD_PERF_CNT_EN undefined: these ports and registers do not exist. Behaviour is otherwise
//    identical.
// TESTING
//  1. ex_MemRead=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> one cycle of pc_wr_en=0, if_id_wr_en=0,
//     id_ex_bubble=1; next cycle (ex_MemRead=0) all enables back to 1.
//  2. ex_MemRead=1, ex_rd=0, id_rs=0, id_uses_rs=1 -> no stall, all enables 1.
//  3. ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1,
//     pc_wr_en=1.
//  4. mem_busy=1 for 3 cycles with ex_branch_taken pulsed in cycle 2 -> all wr_en=0 for 3 cycles;
//     cycle 4 shows the flush and bubble; cycle 5 is normal.
//  5. MAX_WAIT=4, mem_busy held 6 cycles -> mem_timeout=1 from cycle 5, held after mem_busy=0;
//     pulse rst_n low -> mem_timeout=0 and all outputs 0 asynchronously.
//  6. HAZARD_PERF_CNT_EN: run scenarios 1 and 3 -> stall_cycles=1, flush_count=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and MEM wait-state holds.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             if_id_flush,
  output logic             id_ex_wr_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_wr_en,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]     state;
  logic           pend_flush;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           load_use, flush_req;

  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // A pending flush only exists in the first RUN cycle after a wait, while state still reads MEM_WAIT.
  assign flush_req = ex_branch_taken || (pend_flush && (state == MEM_WAIT));

  always_comb begin
    pc_wr_en     = 1'b1;
    if_id_wr_en  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_wr_en  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_wr_en = 1'b1;
    if (!rst_n) begin
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      id_ex_wr_en  = 1'b0;
      ex_mem_wr_en = 1'b0;
    end else if (mem_busy) begin
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      id_ex_wr_en  = 1'b0;
      ex_mem_wr_en = 1'b0;
    end else if (flush_req) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_jump) begin
      if_id_flush  = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_nxt = '0;
    if (mem_busy) wait_cnt_nxt = (wait_cnt == WMAX) ? WMAX : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pend_flush  <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state      <= mem_busy ? MEM_WAIT : RUN;
      pend_flush <= mem_busy && (pend_flush || ex_branch_taken);
      wait_cnt   <= wait_cnt_nxt;
      // Flag rises together with the counter reaching MAX_WAIT and stays until reset.
      if (mem_busy && (wait_cnt_nxt == WMAX)) mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_wr_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; control outputs are checked as one 6-bit vector
// {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_bubble, ex_mem_wr_en}.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, id_jump, ex_MemRead, ex_branch_taken, mem_busy;
  logic pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_bubble, ex_mem_wr_en, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] NORMAL = 6'b110101;
  localparam logic [5:0] HOLD   = 6'b000000;
  localparam logic [5:0] BRANCH = 6'b111111;
  localparam logic [5:0] LU     = 6'b000111;
  localparam logic [5:0] JUMP   = 6'b111101;

  logic [5:0] ctl;
  assign ctl = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_bubble, ex_mem_wr_en};

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush),
    .id_ex_wr_en(id_ex_wr_en), .id_ex_bubble(id_ex_bubble), .ex_mem_wr_en(ex_mem_wr_en),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_MemRead = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if (ctl !== HOLD) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, HOLD); end
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (ctl !== NORMAL) begin errors++; $display("FAIL idle_after_reset: got %b want %b", ctl, NORMAL); end
  endtask

  task automatic test_load_use();
    @(negedge clk); clear_inputs();
    ex_MemRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; #1;
    checks++;
    if (ctl !== LU) begin errors++; $display("FAIL load_use_rs: got %b want %b", ctl, LU); end
    @(negedge clk); ex_MemRead = 1'b0; #1;
    checks++;
    if (ctl !== NORMAL) begin errors++; $display("FAIL load_use_release: got %b want %b", ctl, NORMAL); end
    @(negedge clk); clear_inputs();
    ex_MemRead = 1'b1; ex_rd = 5'd13; id_rt = 5'd13; id_uses_rt = 1'b1; id_rs = 5'd2; id_uses_rs = 1'b1; #1;
    checks++;
    if (ctl !== LU) begin errors++; $display("FAIL load_use_rt: got %b want %b", ctl, LU); end
    @(negedge clk); id_uses_rt = 1'b0; #1;
    checks++;
    if (ctl !== NORMAL) begin errors++; $display("FAIL rt_not_used: got %b want %b", ctl, NORMAL); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); clear_inputs();
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1; #1;
    checks++;
    if (ctl !== NORMAL) begin errors++; $display("FAIL zero_reg: got %b want %b", ctl, NORMAL); end
  endtask

  task automatic test_branch();
    @(negedge clk); clear_inputs();
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; ex_branch_taken = 1'b1; #1;
    checks++;
    if (ctl !== BRANCH) begin errors++; $display("FAIL branch_over_load_use: got %b want %b", ctl, BRANCH); end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (ctl !== NORMAL) begin errors++; $display("FAIL branch_release: got %b want %b", ctl, NORMAL); end
  endtask

  task automatic test_jump();
    @(negedge clk); clear_inputs(); id_jump = 1'b1; #1;
    checks++;
    if (ctl !== JUMP) begin errors++; $display("FAIL jump: got %b want %b", ctl, JUMP); end
    @(negedge clk); ex_MemRead = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; #1;
    checks++;
    if (ctl !== LU) begin errors++; $display("FAIL jump_under_stall: got %b want %b", ctl, LU); end
    @(negedge clk); ex_MemRead = 1'b0; #1;
    checks++;
    if (ctl !== JUMP) begin errors++; $display("FAIL jump_retry: got %b want %b", ctl, JUMP); end
  endtask

  task automatic test_mem_wait();
    logic [5:0] exp [5] = '{HOLD, HOLD, HOLD, BRANCH, NORMAL};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clear_inputs();
      mem_busy = (c < 3);
      ex_branch_taken = (c == 1);
      // Load-use present throughout: the hold and then the flush must both override it.
      ex_MemRead = (c < 4); ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
      #1;
      checks++;
      if (ctl !== exp[c])
        begin errors++; $display("FAIL mem_wait_cycle%0d: got %b want %b", c + 1, ctl, exp[c]); end
    end
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); clear_inputs(); mem_busy = 1'b1; #1;
      checks++;
      if (mem_timeout !== (c >= 5))
        begin errors++; $display("FAIL timeout_cycle%0d: got %b want %b", c, mem_timeout, c >= 5); end
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout); end
    checks++;
    if (ctl !== NORMAL) begin errors++; $display("FAIL timeout_resume: got %b want %b", ctl, NORMAL); end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_async_clear: got %b want 0", mem_timeout); end
    checks++;
    if (ctl !== HOLD) begin errors++; $display("FAIL async_reset_ctl: got %b want %b", ctl, HOLD); end
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk); clear_inputs();
    ex_MemRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    @(negedge clk); ex_MemRead = 1'b0;
    @(negedge clk); ex_MemRead = 1'b1; ex_rd = 5'd8; ex_branch_taken = 1'b1;
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (stall_cycles !== 32'd1) begin errors++; $display("FAIL perf_stall: got %0d want 1", stall_cycles); end
    checks++;
    if (flush_count !== 32'd1) begin errors++; $display("FAIL perf_flush: got %0d want 1", flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_jump();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
